// File: rtl/iterative_div_unit.sv
// Multi-cycle RV32M divide/remainder unit (DIV, DIVU, REM, REMU): restoring division, one quotient bit
// per cycle, then a sign-fix cycle. Optional feature macro: DIV_ZERO_FLAG_EN (adds div_by_zero output).

module iterative_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] opA,
   input  logic [WIDTH-1:0] opB,
   input  logic [2:0]       func,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out
`ifdef DIV_ZERO_FLAG_EN
   ,
   output logic             div_by_zero
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CALC    = 3'd1,
      FIX     = 3'd2,
      SPECIAL = 3'd3,
      DONE    = 3'd4
   } state_t;

   function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
      return (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? negate(x) : x;
   endfunction

   state_t           state;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dividend;
   logic [CNT_W-1:0] cnt;
   logic             sign_a;
   logic             sign_b;
   logic             want_rem;
   logic             spec_zero;
   logic             dz_flag;

   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_next;
   logic             q_bit;
   logic             a_neg;
   logic             b_neg;
   logic             div_zero;
   logic             overflow;

   // One restoring step: the borrow out of the trial subtraction decides the quotient bit.
   always_comb begin
      rem_shift = {rem, dvd[WIDTH-1]};
      trial     = rem_shift - {1'b0, dvs};
      rem_next  = rem_shift[WIDTH-1:0];
      q_bit     = 1'b0;
      if (trial[WIDTH] == 1'b0) begin
         rem_next = trial[WIDTH-1:0];
         q_bit    = 1'b1;
      end else begin
         rem_next = rem_shift[WIDTH-1:0];
         q_bit    = 1'b0;
      end
   end

   // Operand classification at the accept point.
   always_comb begin
      a_neg    = ~func[0] & opA[WIDTH-1];
      b_neg    = ~func[0] & opB[WIDTH-1];
      div_zero = (opB == {WIDTH{1'b0}});
      overflow = ~func[0] & (opA == MIN_NEG) & (opB == ALL_ONES);
   end

   // Control FSM and datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         dvd       <= {WIDTH{1'b0}};
         dvs       <= {WIDTH{1'b0}};
         rem       <= {WIDTH{1'b0}};
         quo       <= {WIDTH{1'b0}};
         dividend  <= {WIDTH{1'b0}};
         cnt       <= {CNT_W{1'b0}};
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
         want_rem  <= 1'b0;
         spec_zero <= 1'b0;
         dz_flag   <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         out       <= {WIDTH{1'b0}};
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  dvd       <= cond_negate(opA, a_neg);
                  dvs       <= cond_negate(opB, b_neg);
                  rem       <= {WIDTH{1'b0}};
                  quo       <= {WIDTH{1'b0}};
                  cnt       <= {CNT_W{1'b0}};
                  dividend  <= opA;
                  sign_a    <= a_neg;
                  sign_b    <= b_neg;
                  want_rem  <= func[1];
                  spec_zero <= div_zero;
                  dz_flag   <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (div_zero || overflow) ? SPECIAL : CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               rem <= rem_next;
               dvd <= {dvd[WIDTH-2:0], 1'b0};
               quo <= {quo[WIDTH-2:0], q_bit};
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_LAST) begin
                  state <= FIX;
               end else begin
                  state <= CALC;
               end
            end
            FIX: begin
               // Remainder takes the dividend's sign; quotient truncates toward zero.
               if (want_rem) begin
                  out <= cond_negate(rem, sign_a);
               end else begin
                  out <= cond_negate(quo, sign_a ^ sign_b);
               end
               busy  <= 1'b0;
               state <= DONE;
            end
            SPECIAL: begin
               if (spec_zero) begin
                  out     <= want_rem ? dividend : ALL_ONES;
                  dz_flag <= 1'b1;
               end else begin
                  out     <= want_rem ? {WIDTH{1'b0}} : MIN_NEG;
                  dz_flag <= 1'b0;
               end
               busy  <= 1'b0;
               state <= DONE;
            end
            DONE: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef DIV_ZERO_FLAG_EN
   assign div_by_zero = dz_flag;
`endif

   iterative_div_unit_checker #(.WIDTH(WIDTH)) u_checker (
      .clk      (clk),
      .reset    (reset),
      .busy     (busy),
      .done     (done),
      .out_write((state == FIX) || (state == SPECIAL)),
      .out      (out)
   );

endmodule

// Protocol properties of the divider outputs.
module iterative_div_unit_checker #(
   parameter int WIDTH = 32
) (
   input logic             clk,
   input logic             reset,
   input logic             busy,
   input logic             done,
   input logic             out_write,
   input logic [WIDTH-1:0] out
);

   a_done_pulse: assert property (@(posedge clk) disable iff (reset) done |=> !done);
   a_done_not_busy: assert property (@(posedge clk) disable iff (reset) !(busy && done));
   a_out_stable: assert property (@(posedge clk) disable iff (reset) !out_write |=> $stable(out));

endmodule
